dm_frame_streamer: RTL and testbench

DM_FRAME_STREAMER -- requirements
Module: dm_frame_streamer

---
 rtl/dm_frame_streamer_pkg.sv | 36 +++
 rtl/dm_stream_skid_fifo.sv | 61 ++++++
 rtl/dm_frame_streamer.sv | 133 +++++++++++++
 tb/tb_dm_frame_streamer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_frame_streamer_pkg.sv
// Shared video definitions for the frame streamer: frame geometry, pixel and
// beat types, FSM state encoding and a beat construction helper.
package dm_frame_streamer_pkg;

  localparam int IMAGE_WIDTH  = 320;
  localparam int IMAGE_HEIGHT = 240;
  localparam int TOTAL_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;

  localparam int ADDR_W  = 17;
  localparam int PIXEL_W = 12;

  // RGB444 pixel: {R[11:8], G[7:4], B[3:0]}
  typedef logic [PIXEL_W-1:0] pixel_t;

  // One stream beat as held in the output FIFO
  typedef struct packed {
    logic   sop;
    logic   eop;
    pixel_t pixel;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic beat_t make_beat(input logic sop, input logic eop, input pixel_t pixel);
    beat_t b;
    b.sop   = sop;
    b.eop   = eop;
    b.pixel = pixel;
    return b;
  endfunction

endpackage

// File: rtl/dm_stream_skid_fifo.sv
// Two-entry show-ahead FIFO holding {sop,eop,pixel} beats between the frame
// RAM read port and the Avalon-ST output. The head entry is always visible.
// Flush empties the FIFO and overrides a simultaneous push.
module dm_stream_skid_fifo
  import dm_frame_streamer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count
);

  localparam int DEPTH = 2;

  beat_t      mem_reg [DEPTH];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       do_push;
  logic       do_pop;

  // The producer never pushes into a full FIFO; pop is ignored when empty
  assign do_push = push && !flush;
  assign do_pop  = pop && (count_reg != 2'd0);

  // Storage write into the slot addressed by the write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_beat;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/dm_frame_streamer.sv
// Streams a frame buffer out over Avalon-ST in raster order. Reads are issued
// against a 1-cycle-latency RAM and land in a 2-entry FIFO; rd_en is gated so
// that FIFO occupancy plus the outstanding read never exceeds the FIFO depth,
// which still allows one beat per clock. While the last pixel of a frame drains,
// the next frame's first reads are prefetched if enable is high, so back-to-back
// frames have no bubble; if enable is low at EOP acceptance the prefetched beats
// are flushed and the streamer goes idle.
module dm_frame_streamer
  import dm_frame_streamer_pkg::*;
#(
  parameter int IMAGE_WIDTH  = dm_frame_streamer_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = dm_frame_streamer_pkg::IMAGE_HEIGHT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PIXEL_W-1:0] rd_data,
  input  logic               ready_in,
  output logic               valid_out,
  output logic               startofpacket_out,
  output logic               endofpacket_out,
  output logic [PIXEL_W-1:0] data_out,
  output logic               busy,
  output logic               frame_done
);

  localparam int               FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_PIXELS - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              pending_reg;     // read issued last cycle, data on rd_data now
  logic              pend_sop_reg;
  logic              pend_eop_reg;
  logic              frame_done_reg;

  beat_t      head;
  logic [1:0] fifo_count;
  logic       fifo_pop;
  logic       fifo_flush;
  logic [2:0] committed;
  logic       room;
  logic       issue;
  logic       eop_accept;

  assign valid_out  = (fifo_count != 2'd0);
  assign fifo_pop   = valid_out && ready_in;
  assign eop_accept = fifo_pop && head.eop;

  // Slots already spoken for: stored beats plus the read in flight, minus the
  // beat leaving this cycle. Cannot underflow because pop implies count >= 1.
  assign committed = {1'b0, fifo_count} + {2'b00, pending_reg} - {2'b00, fifo_pop};
  assign room      = (committed < 3'd2);

  // Prefetched next-frame beats are discarded when the frame ends with enable low
  assign fifo_flush = (state_reg == ST_DRAIN) && eop_accept && !enable;

  // Read issue decode: stream freely in FETCH, prefetch in DRAIN only if continuing
  always_comb begin
    issue = 1'b0;
    unique case (state_reg)
      ST_FETCH: issue = room;
      ST_DRAIN: issue = room && enable;
      default:  issue = 1'b0;
    endcase
  end

  // Frame FSM, address counter, read tagging and frame_done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      pending_reg    <= 1'b0;
      pend_sop_reg   <= 1'b0;
      pend_eop_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= eop_accept;
      pending_reg    <= issue;

      if (issue) begin
        pend_sop_reg <= (addr_reg == '0);
        pend_eop_reg <= (addr_reg == LAST_ADDR);
        addr_reg     <= (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_W'(1);
      end

      unique case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            state_reg <= ST_FETCH;
            addr_reg  <= '0;
          end
        end
        ST_FETCH: begin
          if (issue && (addr_reg == LAST_ADDR)) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (eop_accept) begin
            if (enable) begin
              state_reg <= ST_FETCH;
            end else begin
              state_reg <= ST_IDLE;
              addr_reg  <= '0;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  dm_stream_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (pending_reg),
    .push_beat (make_beat(pend_sop_reg, pend_eop_reg, rd_data)),
    .pop       (fifo_pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign rd_en             = issue;
  assign rd_addr           = addr_reg;
  assign data_out          = head.pixel;
  assign startofpacket_out = valid_out && head.sop;
  assign endofpacket_out   = valid_out && head.eop;
  assign busy              = (state_reg != ST_IDLE);
  assign frame_done        = frame_done_reg;

endmodule

// File: tb/tb_dm_frame_streamer.sv
// Self-checking bench for dm_frame_streamer on a reduced 40x32 frame.
// A frame RAM model returns addr[11:0] ^ key one cycle after rd_en; the
// expected stream is derived from frame geometry alone: beat i carries pixel
// (i mod TOTAL) ^ key, SOP on index 0 of a frame, EOP on index TOTAL-1.
module tb_dm_frame_streamer;

  localparam int W     = 40;
  localparam int H     = 32;
  localparam int TOTAL = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        ready_in = 1'b0;
  logic        rd_en;
  logic [16:0] rd_addr;
  logic [11:0] rd_data = '0;
  logic        valid_out;
  logic        sop;
  logic        eop;
  logic [11:0] data_out;
  logic        busy;
  logic        frame_done;

  logic [11:0] ram_key = '0;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [11:0] data;
    logic        sop;
    logic        eop;
    int          cyc;
  } xfer_t;

  xfer_t got[$];
  int cyc        = 0;
  int fd_count   = 0;
  int fd_viol    = 0;
  int stall_viol = 0;
  int addr_viol  = 0;
  int rd_count   = 0;

  logic        prev_valid    = 1'b0;
  logic        prev_xfer     = 1'b0;
  logic        prev_eop_xfer = 1'b0;
  logic [11:0] prev_data     = '0;
  logic        prev_sop      = 1'b0;
  logic        prev_eop      = 1'b0;

  dm_frame_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .ready_in          (ready_in),
    .valid_out         (valid_out),
    .startofpacket_out (sop),
    .endofpacket_out   (eop),
    .data_out          (data_out),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  always #5 clk = ~clk;

  // Frame RAM model: data valid one cycle after the read strobe
  always @(posedge clk) begin
    cyc++;
    if (rd_en) rd_data <= rd_addr[11:0] ^ ram_key;
  end

  // Bus monitor: records transfers and tallies protocol violations
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid    = 1'b0;
      prev_xfer     = 1'b0;
      prev_eop_xfer = 1'b0;
    end else begin
      if (prev_valid && !prev_xfer &&
          (valid_out !== 1'b1 || data_out !== prev_data || sop !== prev_sop || eop !== prev_eop))
        stall_viol++;
      if (frame_done) begin
        fd_count++;
        if (!prev_eop_xfer) fd_viol++;
      end
      if (rd_en) begin
        rd_count++;
        if (int'(rd_addr) >= TOTAL) addr_viol++;
      end
      if (valid_out && ready_in) got.push_back('{data_out, sop, eop, cyc});
      prev_valid    = valid_out;
      prev_data     = data_out;
      prev_sop      = sop;
      prev_eop      = eop;
      prev_xfer     = valid_out && ready_in;
      prev_eop_xfer = valid_out && ready_in && eop;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; ready_in = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({rd_en, valid_out, sop, eop, busy, frame_done} !== 6'b0)
      $display("FAIL reset_ctrl: got rd_en/valid/sop/eop/busy/fd=%b required 000000",
               {rd_en, valid_out, sop, eop, busy, frame_done});
    else n_pass++;
    n_checks++;
    if (rd_addr !== 17'd0 || data_out !== 12'd0)
      $display("FAIL reset_data: got rd_addr=%0d data_out=%h required 0/000", rd_addr, data_out);
    else n_pass++;
    enable = 1'b0; rst_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0 || rd_en !== 1'b0)
      $display("FAIL idle_hold: got busy=%b valid=%b rd_en=%b required 0/0/0", busy, valid_out, rd_en);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    int base;
    int n;
    ram_key = '0; ready_in = 1'b1; got.delete(); base = fd_count;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n_checks++;
    if (rd_en !== 1'b1 || rd_addr !== 17'd0 || valid_out !== 1'b0 || busy !== 1'b1)
      $display("FAIL latency_clk1: got rd_en=%b addr=%0d valid=%b busy=%b required 1/0/0/1",
               rd_en, rd_addr, valid_out, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (valid_out !== 1'b0 || rd_addr !== 17'd1)
      $display("FAIL latency_clk2: got valid=%b addr=%0d required 0/1", valid_out, rd_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 12'h000 || sop !== 1'b1)
      $display("FAIL first_beat: got valid=%b data=%h sop=%b required 1/000/1", valid_out, data_out, sop);
    else n_pass++;
    n = 0;
    while (fd_count < base + 1 && n < 4 * TOTAL) begin tick(); n++; end
    n_checks++;
    if (fd_count < base + 1) $display("FAIL single_timeout: frame_done count %0d required %0d", fd_count - base, 1);
    else n_pass++;
    repeat (5) tick();
    n_checks++;
    if (got.size() !== TOTAL) $display("FAIL single_count: got %0d beats required %0d", got.size(), TOTAL);
    else n_pass++;
    for (int i = 0; i < TOTAL; i++) begin
      logic [11:0] ed;
      ed = 12'(i % TOTAL) ^ ram_key;
      n_checks++;
      if (i >= got.size())
        $display("FAIL single_beat[%0d]: missing, required %h", i, ed);
      else if (got[i].data !== ed || got[i].sop !== (i % TOTAL == 0) || got[i].eop !== (i % TOTAL == TOTAL - 1))
        $display("FAIL single_beat[%0d]: got %h sop=%b eop=%b required %h", i, got[i].data, got[i].sop, got[i].eop, ed);
      else n_pass++;
    end
    n_checks++;
    if (got.size() < TOTAL || got[TOTAL-1].cyc - got[0].cyc !== TOTAL - 1)
      $display("FAIL single_contiguous: span %0d cycles required %0d",
               got.size() > 0 ? got[got.size()-1].cyc - got[0].cyc : -1, TOTAL - 1);
    else n_pass++;
    n_checks++;
    if (fd_count - base !== 1 || busy !== 1'b0 || valid_out !== 1'b0)
      $display("FAIL single_end: frame_done=%0d busy=%b valid=%b required 1/0/0", fd_count - base, busy, valid_out);
    else n_pass++;
    $display("test_single_frame done: %0d beats", got.size());
  endtask

  task automatic test_random_ready();
    int base;
    int n;
    ram_key = 12'($urandom); got.delete(); base = fd_count;
    ready_in = 1'($urandom_range(0, 1));
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n = 0;
    while (fd_count < base + 1 && n < 10 * TOTAL) begin
      ready_in = 1'($urandom_range(0, 1));
      tick(); n++;
    end
    ready_in = 1'b1;
    n_checks++;
    if (fd_count < base + 1) $display("FAIL random_timeout: frame_done count %0d required 1", fd_count - base);
    else n_pass++;
    repeat (5) tick();
    n_checks++;
    if (got.size() !== TOTAL) $display("FAIL random_count: got %0d beats required %0d", got.size(), TOTAL);
    else n_pass++;
    for (int i = 0; i < TOTAL; i++) begin
      logic [11:0] ed;
      ed = 12'(i % TOTAL) ^ ram_key;
      n_checks++;
      if (i >= got.size())
        $display("FAIL random_beat[%0d]: missing, required %h", i, ed);
      else if (got[i].data !== ed || got[i].sop !== (i % TOTAL == 0) || got[i].eop !== (i % TOTAL == TOTAL - 1))
        $display("FAIL random_beat[%0d]: got %h sop=%b eop=%b required %h", i, got[i].data, got[i].sop, got[i].eop, ed);
      else n_pass++;
    end
    n_checks++;
    if (stall_viol !== 0) $display("FAIL random_stable: %0d unstable stall cycles required 0", stall_viol);
    else n_pass++;
    $display("test_random_ready done: key=%h %0d beats", ram_key, got.size());
  endtask

  task automatic test_stall_hold();
    int base;
    int n;
    int bad;
    int rd_base;
    ram_key = '0; ready_in = 1'b1; got.delete(); base = fd_count;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n = 0;
    while (!(valid_out === 1'b1 && data_out === 12'h3E8) && n < 4 * TOTAL) begin tick(); n++; end
    ready_in = 1'b0;
    rd_base = rd_count; bad = 0;
    repeat (100) begin
      tick();
      if (valid_out !== 1'b1 || data_out !== 12'h3E8) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL stall_hold: %0d cycles lost valid/data 3e8, required 0", bad);
    else n_pass++;
    n_checks++;
    if (rd_count - rd_base > 2) $display("FAIL stall_reads: %0d reads during stall, required <= 2", rd_count - rd_base);
    else n_pass++;
    ready_in = 1'b1;
    n = 0;
    while (fd_count < base + 1 && n < 4 * TOTAL) begin tick(); n++; end
    repeat (5) tick();
    n_checks++;
    if (got.size() !== TOTAL) $display("FAIL stall_count: got %0d beats required %0d", got.size(), TOTAL);
    else n_pass++;
    for (int i = 0; i < TOTAL; i++) begin
      logic [11:0] ed;
      ed = 12'(i % TOTAL) ^ ram_key;
      n_checks++;
      if (i >= got.size())
        $display("FAIL stall_beat[%0d]: missing, required %h", i, ed);
      else if (got[i].data !== ed || got[i].sop !== (i % TOTAL == 0) || got[i].eop !== (i % TOTAL == TOTAL - 1))
        $display("FAIL stall_beat[%0d]: got %h sop=%b eop=%b required %h", i, got[i].data, got[i].sop, got[i].eop, ed);
      else n_pass++;
    end
    $display("test_stall_hold done: %0d beats", got.size());
  endtask

  task automatic test_back_to_back();
    int base;
    int n;
    ram_key = 12'($urandom); ready_in = 1'b1; got.delete(); base = fd_count;
    enable = 1'b1;
    n = 0;
    while (fd_count < base + 1 && n < 4 * TOTAL) begin tick(); n++; end
    enable = 1'b0;
    n = 0;
    while (fd_count < base + 2 && n < 4 * TOTAL) begin tick(); n++; end
    repeat (10) tick();
    n_checks++;
    if (got.size() !== 2 * TOTAL) $display("FAIL b2b_count: got %0d beats required %0d", got.size(), 2 * TOTAL);
    else n_pass++;
    for (int i = 0; i < 2 * TOTAL; i++) begin
      logic [11:0] ed;
      ed = 12'(i % TOTAL) ^ ram_key;
      n_checks++;
      if (i >= got.size())
        $display("FAIL b2b_beat[%0d]: missing, required %h", i, ed);
      else if (got[i].data !== ed || got[i].sop !== (i % TOTAL == 0) || got[i].eop !== (i % TOTAL == TOTAL - 1))
        $display("FAIL b2b_beat[%0d]: got %h sop=%b eop=%b required %h", i, got[i].data, got[i].sop, got[i].eop, ed);
      else n_pass++;
    end
    n_checks++;
    if (got.size() < 2 * TOTAL || got[TOTAL].cyc - got[TOTAL-1].cyc !== 1)
      $display("FAIL b2b_gap: EOP-to-SOP gap %0d cycles required 1",
               got.size() > TOTAL ? got[TOTAL].cyc - got[TOTAL-1].cyc : -1);
    else n_pass++;
    n_checks++;
    if (fd_count - base !== 2 || busy !== 1'b0)
      $display("FAIL b2b_end: frame_done=%0d busy=%b required 2/0", fd_count - base, busy);
    else n_pass++;
    $display("test_back_to_back done: key=%h %0d beats", ram_key, got.size());
  endtask

  task automatic test_enable_drop();
    int base;
    int n;
    ram_key = 12'($urandom); ready_in = 1'b1; got.delete(); base = fd_count;
    enable = 1'b1;
    n = 0;
    while (got.size() < 500 && n < 4 * TOTAL) begin tick(); n++; end
    enable = 1'b0;
    n = 0;
    while (fd_count < base + 1 && n < 4 * TOTAL) begin tick(); n++; end
    repeat (20) tick();
    n_checks++;
    if (got.size() !== TOTAL) $display("FAIL drop_count: got %0d beats required %0d", got.size(), TOTAL);
    else n_pass++;
    for (int i = 0; i < TOTAL; i++) begin
      logic [11:0] ed;
      ed = 12'(i % TOTAL) ^ ram_key;
      n_checks++;
      if (i >= got.size())
        $display("FAIL drop_beat[%0d]: missing, required %h", i, ed);
      else if (got[i].data !== ed || got[i].sop !== (i % TOTAL == 0) || got[i].eop !== (i % TOTAL == TOTAL - 1))
        $display("FAIL drop_beat[%0d]: got %h sop=%b eop=%b required %h", i, got[i].data, got[i].sop, got[i].eop, ed);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0)
      $display("FAIL drop_idle: got busy=%b valid=%b required 0/0", busy, valid_out);
    else n_pass++;
    $display("test_enable_drop done: %0d beats", got.size());
  endtask

  task automatic test_reset_midframe();
    int base;
    int n;
    ram_key = '0; ready_in = 1'b1; got.delete();
    enable = 1'b1;
    n = 0;
    while (got.size() < 700 && n < 4 * TOTAL) begin tick(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_en, valid_out, sop, eop, busy, frame_done} !== 6'b0 || rd_addr !== 17'd0 || data_out !== 12'd0)
      $display("FAIL midreset_outputs: got ctrl=%b addr=%0d data=%h required 000000/0/000",
               {rd_en, valid_out, sop, eop, busy, frame_done}, rd_addr, data_out);
    else n_pass++;
    repeat (3) tick();
    got.delete(); base = fd_count;
    rst_n = 1'b1;
    n = 0;
    while (got.size() < 10 && n < 100) begin tick(); n++; end
    enable = 1'b0;
    n = 0;
    while (fd_count < base + 1 && n < 4 * TOTAL) begin tick(); n++; end
    repeat (5) tick();
    n_checks++;
    if (got.size() == 0 || got[0].data !== 12'h000 || got[0].sop !== 1'b1)
      $display("FAIL midreset_first: got %h sop=%b required 000 sop=1",
               got.size() > 0 ? got[0].data : 12'hxxx, got.size() > 0 ? got[0].sop : 1'bx);
    else n_pass++;
    n_checks++;
    if (got.size() !== TOTAL) $display("FAIL midreset_count: got %0d beats required %0d", got.size(), TOTAL);
    else n_pass++;
    for (int i = 0; i < TOTAL; i++) begin
      logic [11:0] ed;
      ed = 12'(i % TOTAL) ^ ram_key;
      n_checks++;
      if (i >= got.size())
        $display("FAIL midreset_beat[%0d]: missing, required %h", i, ed);
      else if (got[i].data !== ed || got[i].sop !== (i % TOTAL == 0) || got[i].eop !== (i % TOTAL == TOTAL - 1))
        $display("FAIL midreset_beat[%0d]: got %h sop=%b eop=%b required %h", i, got[i].data, got[i].sop, got[i].eop, ed);
      else n_pass++;
    end
    $display("test_reset_midframe done: %0d beats", got.size());
  endtask

  task automatic test_protocol_totals();
    n_checks++;
    if (fd_viol !== 0) $display("FAIL frame_done_timing: %0d misplaced pulses required 0", fd_viol);
    else n_pass++;
    n_checks++;
    if (addr_viol !== 0) $display("FAIL addr_range: %0d out-of-range reads required 0", addr_viol);
    else n_pass++;
    n_checks++;
    if (stall_viol !== 0) $display("FAIL stall_stable: %0d unstable stall cycles required 0", stall_viol);
    else n_pass++;
    $display("test_protocol_totals done");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_random_ready();
    test_stall_hold();
    test_back_to_back();
    test_enable_drop();
    test_reset_midframe();
    test_protocol_totals();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
